reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer that allocates rename tags to the decoder, collects results from the common data bus (CDB), and retires instructions in program order. At retirement it drives the register file's write-back port: register index, ROB tag and value. It also drives the register file's rollback input when a mispredicted branch retires. It is the producer end of the register file's rename/commit interface.

## Interface

Parameters:
- DEPTH, 15: number of entries. Tags run 1..DEPTH; tag 0 (`ZERO_ROB`) means "no tag".

Ports (`REG_WIDTH`, `ROB_WIDTH` and `DATA_WIDTH` are the shared widths):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low (asserted at 0).
- ena  in  1  global enable; when 0, all state holds.
- in_alloc_valid  in  1  decoder allocates one entry this cycle.
- in_alloc_rd  in  `REG_WIDTH`  destination register; 0 means no write-back.
- in_alloc_is_branch  in  1  entry is a branch.
- out_alloc_tag  out  `ROB_WIDTH`  tag the next allocation receives (combinational).
- out_full  out  1  no free entry (combinational).
- in_cdb_valid  in  1  CDB broadcast valid.
- in_cdb_tag  in  `ROB_WIDTH`  broadcast tag.
- in_cdb_value  in  `DATA_WIDTH`  result.
- in_cdb_mispredict  in  1  branch resolved as mispredicted.
- in_query_tag1, in_query_tag2  in  `ROB_WIDTH`  operand tags from the decoder.
- out_query_ready1, out_query_ready2  out  1  the tag's result is available.
- out_query_value1, out_query_value2  out  `DATA_WIDTH`  the tag's result.
- out_commit_reg_index  out  `REG_WIDTH`  register to write; 0 means no commit.
- out_commit_rob_tag  out  `ROB_WIDTH`  tag of the retiring entry.
- out_commit_value  out  `DATA_WIDTH`  value to write.
- out_rollback  out  1  one-cycle flush pulse.

## Operation

- Per-entry state: valid, ready, rd, is_branch, mispredict, value. Pointers head and tail range 0..DEPTH-1 and wrap. A count tracks occupancy. Entry i carries tag i+1.
- **Allocate:** accepted when in_alloc_valid=1, out_full=0 and no rollback is issued in the same cycle. The entry at tail is written with valid=1 and ready=0, then tail advances. An allocate request while full is dropped; the decoder must check out_full.
- **Write-back:** on in_cdb_valid, the entry matching in_cdb_tag gets ready=1, value and mispredict. A broadcast to an invalid entry, or to tag 0, is ignored.
- **Commit:** at most one entry per cycle. If the head entry is valid and ready, it retires: head advances and count decrements.
  - Non-branch entry: out_commit_* take rd, tag and value on the next edge.
  - Branch entry: out_commit_reg_index = 0.
  - Branch entry with mispredict=1: additionally out_rollback=1 on the next edge. All entries are invalidated, head=tail=count=0, and any allocate or CDB write in that cycle is discarded.
- **Query:** out_query_ready*=1 when the tag's entry is valid and ready. A same-cycle CDB broadcast with a matching tag is bypassed. Tag 0 returns ready=0, value 0.
- **Simultaneous allocate and commit:** both occur and count is unchanged. out_full uses the pre-commit count, so a full buffer never allocates in the cycle it retires.
- **ena=0:** no state change, out_commit_reg_index=0, out_rollback=0.

## Timing

- Reset values: out_commit_reg_index=0, out_commit_rob_tag=0, out_commit_value=0, out_rollback=0, out_full=0, out_alloc_tag=1. All valid bits 0, head=tail=count=0.
- Reset during operation flushes all entries without issuing a rollback pulse.
- CDB write at edge N allows commit of that head entry at edge N+1; the commit outputs are visible after edge N+1.
- Commit outputs are registered and hold for exactly one cycle, then return to reg 0 unless another commit follows.
- out_rollback is high for exactly one cycle. The decoder's first allocate after the flush receives tag 1.
- Tag wraps from DEPTH back to 1.

## Structure

- `REG_WIDTH`, `ROB_WIDTH`, `DATA_WIDTH`, `ZERO_ROB`, `ZERO_REG`, `ZERO_DATA`, `TRUE` and `FALSE` live in the shared constant.v.
- A single module; no sub-module is warranted.

## Test plan

- After reset: allocate rd=5 (tag 1), CDB tag 1 value 0xDEAD -> commit reg 5, tag 1, value 0xDEAD two edges after the CDB write; out_full=0.
- Fill all 15 entries -> out_full=1; a 16th allocate is dropped. Write back tag 1 -> commit; the next allocate receives tag 1 (wrap).
- Out-of-order CDB writes (tag 3, then 2, then 1) -> commits appear in order 1, 2, 3 on consecutive cycles.
- Branch at tag 2 with mispredict, tags 3-4 allocated -> tag 1 commits, then tag 2 retires with reg 0 and out_rollback=1 for one cycle; the next allocate gets tag 1.
- Query tag 4 while CDB broadcasts tag 4 value 7 -> ready=1, value 7 in the same cycle.
- Drive rst=0 while entries are pending -> all outputs at reset values, no rollback pulse, out_alloc_tag=1.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared widths, zero/boolean constants and entry types for the reorder buffer
// and its rename/commit interface.
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

    localparam int REG_WIDTH  = 5;
    localparam int ROB_WIDTH  = 4;
    localparam int DATA_WIDTH = 32;

    localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
    localparam logic [REG_WIDTH-1:0]  ZERO_REG  = '0;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
    localparam logic                  TRUE      = 1'b1;
    localparam logic                  FALSE     = 1'b0;

    typedef logic [ROB_WIDTH-1:0] rob_tag_t;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic                  is_branch;
        logic                  mispredict;
        logic [REG_WIDTH-1:0]  rd;
        logic [DATA_WIDTH-1:0] value;
    } rob_entry_t;

    typedef struct packed {
        logic                  ready;
        logic [DATA_WIDTH-1:0] value;
    } rob_query_t;

    // Circular pointer increment over 0..depth-1.
    function automatic rob_tag_t ptr_inc(rob_tag_t p, int unsigned depth);
        return (p == rob_tag_t'(depth - 1)) ? ZERO_ROB : p + 1'b1;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Decoder / CDB / register-file side signals of the reorder buffer.
//   master : decoder + CDB driver (drives in_*, observes out_*)
//   slave  : reorder buffer (observes in_*, drives out_*)
// Allocation : in_alloc_valid/rd/is_branch -> out_alloc_tag, out_full
// CDB        : in_cdb_valid/tag/value/mispredict
// Query      : in_query_tag1/2 -> out_query_ready1/2, out_query_value1/2
// Commit     : out_commit_reg_index/rob_tag/value, out_rollback
// -----------------------------------------------------------------------------
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic                  in_alloc_valid;
    logic [REG_WIDTH-1:0]  in_alloc_rd;
    logic                  in_alloc_is_branch;
    logic [ROB_WIDTH-1:0]  out_alloc_tag;
    logic                  out_full;

    logic                  in_cdb_valid;
    logic [ROB_WIDTH-1:0]  in_cdb_tag;
    logic [DATA_WIDTH-1:0] in_cdb_value;
    logic                  in_cdb_mispredict;

    logic [ROB_WIDTH-1:0]  in_query_tag1;
    logic [ROB_WIDTH-1:0]  in_query_tag2;
    logic                  out_query_ready1;
    logic                  out_query_ready2;
    logic [DATA_WIDTH-1:0] out_query_value1;
    logic [DATA_WIDTH-1:0] out_query_value2;

    logic [REG_WIDTH-1:0]  out_commit_reg_index;
    logic [ROB_WIDTH-1:0]  out_commit_rob_tag;
    logic [DATA_WIDTH-1:0] out_commit_value;
    logic                  out_rollback;

    modport master (
        output in_alloc_valid, in_alloc_rd, in_alloc_is_branch,
        output in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_mispredict,
        output in_query_tag1, in_query_tag2,
        input  out_alloc_tag, out_full,
        input  out_query_ready1, out_query_ready2, out_query_value1, out_query_value2,
        input  out_commit_reg_index, out_commit_rob_tag, out_commit_value, out_rollback
    );

    modport slave (
        input  in_alloc_valid, in_alloc_rd, in_alloc_is_branch,
        input  in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_mispredict,
        input  in_query_tag1, in_query_tag2,
        output out_alloc_tag, out_full,
        output out_query_ready1, out_query_ready2, out_query_value1, out_query_value2,
        output out_commit_reg_index, out_commit_rob_tag, out_commit_value, out_rollback
    );

endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular reorder buffer: hands out rename tags (1..DEPTH, 0 = no tag),
// captures CDB results, retires one entry per cycle in program order onto the
// register-file write-back port and flushes on a mispredicted branch.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active low
//   ena  - global enable; 0 holds all state and suppresses commit/rollback
//   bus  - reorder_buffer_if.slave (allocate, CDB, query, commit, rollback)
// -----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    reorder_buffer_if.slave  bus
);

    rob_entry_t            ent_q [DEPTH];
    rob_entry_t            ent_d [DEPTH];
    rob_tag_t              head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [REG_WIDTH-1:0]  commit_reg_q, commit_reg_d;
    rob_tag_t              commit_tag_q, commit_tag_d;
    logic [DATA_WIDTH-1:0] commit_val_q, commit_val_d;
    logic                  rollback_q, rollback_d;

    rob_entry_t head_ent;
    logic       full, commit_fire, rollback_fire, alloc_fire;
    rob_tag_t   cdb_idx;
    rob_query_t q1, q2;

    // A tag names a live entry only when non-zero, in range and valid.
    function automatic logic tag_live(rob_tag_t tag);
        logic live;
        live = FALSE;
        if (tag != ZERO_ROB && 32'(tag) <= DEPTH)
            live = ent_q[tag - 1'b1].valid;
        return live;
    endfunction

    // Same-cycle CDB broadcast takes precedence over the stored result.
    function automatic rob_query_t lookup(rob_tag_t tag);
        rob_query_t r;
        r.ready = FALSE;
        r.value = ZERO_DATA;
        if (tag_live(tag)) begin
            if (bus.in_cdb_valid && bus.in_cdb_tag == tag) begin
                r.ready = TRUE;
                r.value = bus.in_cdb_value;
            end else if (ent_q[tag - 1'b1].ready) begin
                r.ready = TRUE;
                r.value = ent_q[tag - 1'b1].value;
            end
        end
        return r;
    endfunction

    assign head_ent      = ent_q[head_q];
    assign full          = (count_q == rob_tag_t'(DEPTH));
    assign commit_fire   = ena && head_ent.valid && head_ent.ready;
    assign rollback_fire = commit_fire && head_ent.is_branch && head_ent.mispredict;
    // full is the pre-commit occupancy, so a full buffer never allocates while retiring.
    assign alloc_fire    = ena && bus.in_alloc_valid && !full && !rollback_fire;
    assign cdb_idx       = bus.in_cdb_tag - 1'b1;
    assign q1            = lookup(bus.in_query_tag1);
    assign q2            = lookup(bus.in_query_tag2);

    always_comb begin
        ent_d        = ent_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        commit_reg_d = ZERO_REG;
        commit_tag_d = ZERO_ROB;
        commit_val_d = ZERO_DATA;
        rollback_d   = FALSE;

        if (commit_fire) begin
            commit_reg_d = head_ent.is_branch ? ZERO_REG : head_ent.rd;
            commit_tag_d = head_q + 1'b1;
            commit_val_d = head_ent.value;
            rollback_d   = rollback_fire;
        end

        if (rollback_fire) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_d[i].valid = FALSE;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (ena && bus.in_cdb_valid && tag_live(bus.in_cdb_tag)) begin
                ent_d[cdb_idx].ready      = TRUE;
                ent_d[cdb_idx].value      = bus.in_cdb_value;
                ent_d[cdb_idx].mispredict = bus.in_cdb_mispredict;
            end
            if (commit_fire) begin
                ent_d[head_q].valid = FALSE;
                head_d = ptr_inc(head_q, DEPTH);
            end
            if (alloc_fire) begin
                ent_d[tail_q] = '{valid: TRUE, ready: FALSE,
                                  is_branch: bus.in_alloc_is_branch, mispredict: FALSE,
                                  rd: bus.in_alloc_rd, value: ZERO_DATA};
                tail_d = ptr_inc(tail_q, DEPTH);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // With ena=0 the _d values already equal the held state and idle commit outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_reg_q <= ZERO_REG;
            commit_tag_q <= ZERO_ROB;
            commit_val_q <= ZERO_DATA;
            rollback_q   <= FALSE;
        end else begin
            ent_q        <= ent_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            commit_reg_q <= commit_reg_d;
            commit_tag_q <= commit_tag_d;
            commit_val_q <= commit_val_d;
            rollback_q   <= rollback_d;
        end
    end

    assign bus.out_alloc_tag        = tail_q + 1'b1;
    assign bus.out_full             = full;
    assign bus.out_query_ready1     = q1.ready;
    assign bus.out_query_value1     = q1.value;
    assign bus.out_query_ready2     = q2.ready;
    assign bus.out_query_value2     = q2.value;
    assign bus.out_commit_reg_index = commit_reg_q;
    assign bus.out_commit_rob_tag   = commit_tag_q;
    assign bus.out_commit_value     = commit_val_q;
    assign bus.out_rollback         = rollback_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Directed stimulus for reorder_buffer. A queue-based program-order model
// tracks the in-flight instructions; every falling edge all outputs are
// compared with it, and literal checks pin key points of each scenario.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b1;

    reorder_buffer_if bus();

    reorder_buffer #(.DEPTH(15)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // ---------------- model: in-flight instructions in program order --------
    typedef struct {
        int          tag;
        int          rd;
        bit          br;
        bit          ready;
        bit          mp;
        logic [31:0] value;
    } ent_t;

    ent_t        mq[$];
    int          next_tag = 1;
    int          e_reg = 0, e_tag = 0, e_rb = 0;
    logic [31:0] e_val = 0;

    always @(posedge clk) begin
        bit   do_commit, do_rb, was_full;
        ent_t e;
        if (!rst) begin
            mq.delete();
            next_tag = 1;
            e_reg = 0; e_tag = 0; e_val = 0; e_rb = 0;
        end else if (!ena) begin
            e_reg = 0; e_tag = 0; e_val = 0; e_rb = 0;
        end else begin
            was_full  = (mq.size() == 15);
            do_commit = (mq.size() > 0) && mq[0].ready;
            do_rb     = do_commit && mq[0].br && mq[0].mp;
            e_reg = 0; e_tag = 0; e_val = 0; e_rb = 0;
            if (do_commit) begin
                e_reg = mq[0].br ? 0 : mq[0].rd;
                e_tag = mq[0].tag;
                e_val = mq[0].value;
                e_rb  = do_rb ? 1 : 0;
            end
            if (do_rb) begin
                mq.delete();
                next_tag = 1;
            end else begin
                if (bus.in_cdb_valid)
                    for (int i = 0; i < mq.size(); i++)
                        if (mq[i].tag == int'(bus.in_cdb_tag)) begin
                            e = mq[i];
                            e.ready = 1; e.value = bus.in_cdb_value; e.mp = bus.in_cdb_mispredict;
                            mq[i] = e;
                        end
                if (do_commit) void'(mq.pop_front());
                if (bus.in_alloc_valid && !was_full) begin
                    e.tag = next_tag; e.rd = int'(bus.in_alloc_rd); e.br = bus.in_alloc_is_branch;
                    e.ready = 0; e.mp = 0; e.value = 0;
                    mq.push_back(e);
                    next_tag = (next_tag == 15) ? 1 : next_tag + 1;
                end
            end
        end
    end

    function automatic void model_query(input int tag, output bit rdy, output logic [31:0] val);
        rdy = 0;
        val = 0;
        if (tag == 0) return;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == tag) begin
                if (bus.in_cdb_valid && int'(bus.in_cdb_tag) == tag) begin
                    rdy = 1; val = bus.in_cdb_value;
                end else if (mq[i].ready) begin
                    rdy = 1; val = mq[i].value;
                end
            end
    endfunction

    // ---------------- compare process ---------------------------------------
    always @(negedge clk) begin
        bit          r;
        logic [31:0] v;
        check("alloc_tag",  32'(bus.out_alloc_tag), next_tag);
        check("full",       32'(bus.out_full), (mq.size() == 15) ? 1 : 0);
        check("commit_reg", 32'(bus.out_commit_reg_index), e_reg);
        check("commit_tag", 32'(bus.out_commit_rob_tag), e_tag);
        check("commit_val", bus.out_commit_value, e_val);
        check("rollback",   32'(bus.out_rollback), e_rb);
        model_query(int'(bus.in_query_tag1), r, v);
        check("q1_ready", 32'(bus.out_query_ready1), 32'(r));
        if (r || bus.in_query_tag1 == 0) check("q1_value", bus.out_query_value1, v);
        model_query(int'(bus.in_query_tag2), r, v);
        check("q2_ready", 32'(bus.out_query_ready2), 32'(r));
        if (r || bus.in_query_tag2 == 0) check("q2_value", bus.out_query_value2, v);
    end

    // ---------------- driver -------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_alloc_valid     = 1'b0;
        bus.in_alloc_rd        = '0;
        bus.in_alloc_is_branch = 1'b0;
        bus.in_cdb_valid       = 1'b0;
        bus.in_cdb_tag         = '0;
        bus.in_cdb_value       = '0;
        bus.in_cdb_mispredict  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic alloc(input int rd, input bit br);
        bus.in_alloc_valid     = 1'b1;
        bus.in_alloc_rd        = 5'(rd);
        bus.in_alloc_is_branch = br;
        tick();
        idle();
    endtask

    task automatic cdb(input int tag, input logic [31:0] val, input bit mp);
        bus.in_cdb_valid      = 1'b1;
        bus.in_cdb_tag        = 4'(tag);
        bus.in_cdb_value      = val;
        bus.in_cdb_mispredict = mp;
        tick();
        idle();
    endtask

    initial begin
        idle();
        bus.in_query_tag1 = '0;
        bus.in_query_tag2 = '0;

        // 1: single instruction round trip
        do_reset();
        check("rst_alloc_tag", 32'(bus.out_alloc_tag), 1);
        check("rst_full", 32'(bus.out_full), 0);
        check("rst_commit_reg", 32'(bus.out_commit_reg_index), 0);
        check("rst_rollback", 32'(bus.out_rollback), 0);
        alloc(5, 0);
        check("t1_alloc_tag", 32'(bus.out_alloc_tag), 2);
        cdb(1, 32'hDEAD, 0);
        check("t1_no_early_commit", 32'(bus.out_commit_reg_index), 0);
        tick();
        check("t1_commit_reg", 32'(bus.out_commit_reg_index), 5);
        check("t1_commit_tag", 32'(bus.out_commit_rob_tag), 1);
        check("t1_commit_val", bus.out_commit_value, 32'hDEAD);
        check("t1_full", 32'(bus.out_full), 0);
        tick();
        check("t1_commit_clears", 32'(bus.out_commit_reg_index), 0);

        // 2: fill, drop when full, wrap
        do_reset();
        bus.in_query_tag1 = 4'd1;
        bus.in_query_tag2 = 4'd15;
        for (int i = 1; i <= 15; i++) alloc(i, 0);
        check("t2_full", 32'(bus.out_full), 1);
        check("t2_full_alloc_tag", 32'(bus.out_alloc_tag), 1);
        alloc(9, 0);
        check("t2_drop_full", 32'(bus.out_full), 1);
        check("t2_drop_tag", 32'(bus.out_alloc_tag), 1);
        cdb(1, 32'h100, 0);
        tick();
        check("t2_commit_tag", 32'(bus.out_commit_rob_tag), 1);
        check("t2_commit_reg", 32'(bus.out_commit_reg_index), 1);
        check("t2_not_full", 32'(bus.out_full), 0);
        check("t2_wrap_tag", 32'(bus.out_alloc_tag), 1);
        alloc(3, 0);
        check("t2_refull", 32'(bus.out_full), 1);
        check("t2_after_wrap", 32'(bus.out_alloc_tag), 2);
        cdb(2, 32'h200, 0);
        bus.in_alloc_valid = 1'b1;
        bus.in_alloc_rd    = 5'd4;
        tick();
        idle();
        check("t2_retire_full_tag", 32'(bus.out_commit_rob_tag), 2);
        check("t2_retire_full_noalloc", 32'(bus.out_alloc_tag), 2);
        check("t2_retire_full_flag", 32'(bus.out_full), 0);

        // 3: out-of-order write-back, in-order retirement
        do_reset();
        bus.in_query_tag1 = 4'd1;
        bus.in_query_tag2 = 4'd3;
        alloc(1, 0); alloc(2, 0); alloc(3, 0);
        cdb(3, 30, 0); cdb(2, 20, 0); cdb(1, 10, 0);
        tick();
        check("t3_c1_tag", 32'(bus.out_commit_rob_tag), 1);
        check("t3_c1_val", bus.out_commit_value, 10);
        tick();
        check("t3_c2_tag", 32'(bus.out_commit_rob_tag), 2);
        check("t3_c2_val", bus.out_commit_value, 20);
        tick();
        check("t3_c3_tag", 32'(bus.out_commit_rob_tag), 3);
        check("t3_c3_reg", 32'(bus.out_commit_reg_index), 3);
        tick();
        check("t3_idle_tag", 32'(bus.out_commit_rob_tag), 0);

        // 4: mispredicted branch flush
        do_reset();
        bus.in_query_tag1 = 4'd3;
        bus.in_query_tag2 = 4'd2;
        alloc(7, 0); alloc(0, 1); alloc(8, 0); alloc(9, 0);
        cdb(2, 32'h22, 1);
        cdb(1, 32'h11, 0);
        tick();
        check("t4_c1_reg", 32'(bus.out_commit_reg_index), 7);
        check("t4_c1_rb", 32'(bus.out_rollback), 0);
        bus.in_alloc_valid = 1'b1;
        bus.in_alloc_rd    = 5'd4;
        bus.in_cdb_valid   = 1'b1;
        bus.in_cdb_tag     = 4'd3;
        bus.in_cdb_value   = 32'h33;
        tick();
        idle();
        check("t4_br_reg", 32'(bus.out_commit_reg_index), 0);
        check("t4_br_tag", 32'(bus.out_commit_rob_tag), 2);
        check("t4_rollback", 32'(bus.out_rollback), 1);
        check("t4_flush_tag", 32'(bus.out_alloc_tag), 1);
        tick();
        check("t4_rb_pulse_end", 32'(bus.out_rollback), 0);
        alloc(6, 0);
        check("t4_first_after_flush", 32'(bus.out_alloc_tag), 2);

        // 5: query with same-cycle CDB bypass
        do_reset();
        for (int i = 1; i <= 4; i++) alloc(i, 0);
        bus.in_query_tag1 = 4'd4;
        bus.in_query_tag2 = 4'd0;
        bus.in_cdb_valid  = 1'b1;
        bus.in_cdb_tag    = 4'd4;
        bus.in_cdb_value  = 32'd7;
        #1;
        check("t5_bypass_ready", 32'(bus.out_query_ready1), 1);
        check("t5_bypass_value", bus.out_query_value1, 7);
        check("t5_tag0_ready", 32'(bus.out_query_ready2), 0);
        check("t5_tag0_value", bus.out_query_value2, 0);
        tick();
        idle();
        bus.in_query_tag2 = 4'd3;
        #1;
        check("t5_stored_value", bus.out_query_value1, 7);
        check("t5_pending_ready", 32'(bus.out_query_ready2), 0);

        // 6: enable hold, then reset while entries pending
        cdb(1, 32'h55, 0);
        ena = 1'b0;
        bus.in_alloc_valid = 1'b1;
        bus.in_alloc_rd    = 5'd12;
        tick();
        tick();
        idle();
        check("t6_hold_reg", 32'(bus.out_commit_reg_index), 0);
        check("t6_hold_tag", 32'(bus.out_alloc_tag), 5);
        ena = 1'b1;
        tick();
        check("t6_resume_reg", 32'(bus.out_commit_reg_index), 1);
        check("t6_resume_val", bus.out_commit_value, 32'h55);
        alloc(10, 0);
        cdb(2, 32'h66, 0);
        rst = 1'b0;
        tick();
        check("t6_rst_reg", 32'(bus.out_commit_reg_index), 0);
        check("t6_rst_tag", 32'(bus.out_commit_rob_tag), 0);
        check("t6_rst_val", bus.out_commit_value, 0);
        check("t6_rst_rb", 32'(bus.out_rollback), 0);
        check("t6_rst_alloc", 32'(bus.out_alloc_tag), 1);
        check("t6_rst_full", 32'(bus.out_full), 0);
        rst = 1'b1;
        tick();
        check("t6_no_commit_after_rst", 32'(bus.out_commit_reg_index), 0);
        alloc(5, 0);
        check("t6_alloc_after_rst", 32'(bus.out_alloc_tag), 2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
